// File: rtl/serial_operand_tx_pkg.sv
// serial_add_pkg: shared state type, default sizes and counter sizing for serial_operand_tx.
package serial_add_pkg;
    typedef enum logic {S_IDLE, S_SHIFT} tx_state_e;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;
    function automatic int cnt_bits(input int width);
        return $clog2(width);
    endfunction
endpackage

// File: rtl/serial_operand_tx_piso_shift.sv
// piso_shift: two-lane parallel-in/serial-out shift register, LSB exposed on o_a/o_b.
module piso_shift
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_a,
    output logic             o_b
);
    logic [WIDTH-1:0] r_a, r_b;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
        end else if (i_load) begin
            r_a <= i_a;
            r_b <= i_b;
        end else if (i_shift) begin
            r_a <= r_a >> 1;
            r_b <= r_b >> 1;
        end
    end
    assign o_a = r_a[0];
    assign o_b = r_b[0];
endmodule

// File: rtl/serial_operand_tx.sv
// serial_operand_tx: shifts accepted operand pairs out LSB-first on in1/in2 framed by en_i.
// Define SERIAL_TX_BACK2BACK_EN to accept the next pair on the last bit cycle (gapless frames).
module serial_operand_tx
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             en_i,
    output logic             in1,
    output logic             in2,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] frames_sent
);
    localparam int CW = cnt_bits(WIDTH);
    tx_state_e r_state, w_state_nx;
    logic [CW-1:0] r_cnt;
    logic w_hs, w_last, w_sa, w_sb;
    assign w_last = (r_state == S_SHIFT) && (r_cnt == '0);
`ifdef SERIAL_TX_BACK2BACK_EN
    assign op_ready = (r_state == S_IDLE) || w_last;
`else
    assign op_ready = (r_state == S_IDLE);
`endif
    assign w_hs = op_valid && op_ready;
    always_comb begin
        w_state_nx = r_state;
        w_state_nx = w_hs ? S_SHIFT : (w_last ? S_IDLE : r_state);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end
    // bit 0 goes straight to the wire, so the shifter only holds the remaining bits
    piso_shift #(.WIDTH(WIDTH)) u_piso (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_hs),
        .i_shift ((r_state == S_SHIFT) && !w_last),
        .i_a     (op_a >> 1),
        .i_b     (op_b >> 1),
        .o_a     (w_sa),
        .o_b     (w_sb)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_i        <= 1'b0;
            in1         <= 1'b0;
            in2         <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frames_sent <= '0;
            r_cnt       <= '0;
        end else begin
            frame_done  <= w_last;
            frames_sent <= frames_sent + CNT_W'(w_last);
            busy        <= (w_state_nx == S_SHIFT);
            if (w_hs) begin
                en_i  <= 1'b1;
                in1   <= op_a[0];
                in2   <= op_b[0];
                r_cnt <= CW'(WIDTH - 1);
            end else if (w_last) begin
                en_i <= 1'b0;
                in1  <= 1'b0;
                in2  <= 1'b0;
            end else if (r_state == S_SHIFT) begin
                in1   <= w_sa;
                in2   <= w_sb;
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_serial_operand_tx.sv
// tb_serial_operand_tx: directed + random frames checked against a queue-based stream model.
module tb_serial_operand_tx;
    logic       clk, rst_n, op_valid, op_ready;
    logic [7:0] op_a, op_b;
    logic       en_i, in1, in2, busy, frame_done;
    logic [3:0] frames_sent;

    serial_operand_tx #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .en_i(en_i), .in1(in1), .in2(in2),
        .busy(busy), .frame_done(frame_done), .frames_sent(frames_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0, errors = 0;
    logic [7:0] pa[$], pb[$];
    bit cap1[$], cap2[$];
    int runs[$], gaps[$];
    int run = 0, gap = 0, done_cnt = 0, exp_frames = 0;
    bit had_run = 0;
    int bp, bc, br, bd;

    // wire monitor: records every bit on the wire plus en_i run and gap lengths
    always @(negedge clk) begin
        if (!rst_n) begin
            run = 0; gap = 0; had_run = 0;
        end else begin
            if (en_i) begin
                if (run == 0 && had_run) gaps.push_back(gap);
                cap1.push_back(in1); cap2.push_back(in2);
                run++; gap = 0;
            end else begin
                if (run != 0) begin runs.push_back(run); had_run = 1; end
                run = 0; gap++;
            end
            if (frame_done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        bp = pa.size(); bc = cap1.size(); br = runs.size(); bd = done_cnt;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input bit keep, input bit junk);
        int t = 0;
        op_valid = 1'b1;
        if (junk) begin op_a = 8'($urandom); op_b = 8'($urandom); end
        while (!op_ready && t < 40) begin
            @(negedge clk);
            t++;
            if (junk) begin op_a = 8'($urandom); op_b = 8'($urandom); end
        end
        check("ready_wait", 32'(op_ready), 1);
        op_a = a; op_b = b;
        pa.push_back(a); pb.push_back(b); exp_frames++;
        @(negedge clk);
        check("first_bit_en", 32'(en_i), 1);
        check("first_bit_a", 32'(in1), 32'(a[0]));
        check("first_bit_b", 32'(in2), 32'(b[0]));
        check("busy", 32'(busy), 1);
        if (!keep) begin op_valid = 1'b0; op_a = 8'($urandom); op_b = 8'($urandom); end
    endtask

    task automatic verify(input string tag);
        int t = 0, n, k;
        while ((busy || en_i) && t < 200) begin @(negedge clk); t++; end
        check({tag, "_drain"}, 32'(busy || en_i), 0);
        @(negedge clk);
        n = pa.size() - bp;
        check({tag, "_nbits"}, 32'(cap1.size() - bc), 32'(n * 8));
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 8; j++) begin
                k = bc + i * 8 + j;
                if (k < cap1.size()) begin
                    check({tag, "_in1"}, 32'(cap1[k]), 32'(pa[bp + i][j]));
                    check({tag, "_in2"}, 32'(cap2[k]), 32'(pb[bp + i][j]));
                end
            end
        check({tag, "_done"}, 32'(done_cnt - bd), 32'(n));
        check({tag, "_count"}, 32'(frames_sent), 32'(exp_frames % 16));
    endtask

    initial begin
        int r0, r1, lg, d0;
        rst_n = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0;
        #3;
        check("rst_en", 32'(en_i), 0);
        check("rst_in1", 32'(in1), 0);
        check("rst_in2", 32'(in2), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(frame_done), 0);
        check("rst_count", 32'(frames_sent), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_ready", 32'(op_ready), 1);

        mark();
        send(8'hA5, 8'h3C, 0, 0);
        check("ready_low_busy", 32'(op_ready), 0);
        verify("single");
        check("single_run", 32'((runs.size() > br) ? runs[br] : -1), 8);

        mark();
        send(8'($urandom), 8'($urandom), 1, 0);
        send(8'($urandom), 8'($urandom), 0, 0);
        verify("pair");
        r0 = (runs.size() > br) ? runs[br] : -1;
        r1 = (runs.size() > br + 1) ? runs[br + 1] : -1;
        lg = (gaps.size() > 0) ? gaps[gaps.size() - 1] : -1;
`ifdef SERIAL_TX_BACK2BACK_EN
        check("pair_nruns", 32'(runs.size() - br), 1);
        check("pair_run", 32'(r0), 16);
`else
        check("pair_nruns", 32'(runs.size() - br), 2);
        check("pair_run0", 32'(r0), 8);
        check("pair_run1", 32'(r1), 8);
        check("pair_gap", 32'(lg), 1);
`endif

        mark();
        send(8'($urandom), 8'($urandom), 1, 0);
        send(8'($urandom), 8'($urandom), 0, 1);
        verify("hold");

        mark();
        send(8'($urandom), 8'($urandom), 0, 0);
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_en", 32'(en_i), 0);
        check("mid_rst_in1", 32'(in1), 0);
        check("mid_rst_in2", 32'(in2), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_count", 32'(frames_sent), 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_ready", 32'(op_ready), 1);
        check("mid_rst_nodone", 32'(done_cnt), 32'(d0));
        void'(pa.pop_back()); void'(pb.pop_back());
        exp_frames = 0;
        mark();
        send(8'($urandom), 8'($urandom), 0, 0);
        verify("after_rst");

        for (int f = 0; f < 20; f++) begin
            mark();
            send(8'($urandom), 8'($urandom), 0, 1'($urandom));
            verify("rand");
            if (exp_frames == 16) check("wrap", 32'(frames_sent), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
